// File: rtl/data_memory_ctl.sv
// -----------------------------------------------------------------------------
// data_memory_ctl
//   Single-port data memory sitting between the CPU load/store unit and on-chip
//   RAM. Requests use a valid/ready handshake. Writes are byte-lane masked.
//   Reads return one cycle after acceptance. Out-of-range accesses raise a
//   one-cycle addr_err. After reset the array is cleared one word per clock
//   before requests are accepted.
//
//   Optional feature macro: DMEM_PARITY_EN
//     When defined, each byte lane stores an even-parity bit. The err_inject
//     input and the parity_err output are added.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    controller accepts a request this cycle (READY state)
//   write_enable 1 = write, 0 = read
//   address      word address
//   data_input   write data
//   byte_en      per-lane write enable
//   rsp_valid    one-cycle pulse: data_output holds read data
//   data_output  read data, holds last read value between responses
//   addr_err     one-cycle pulse for an accepted request with address >= DEPTH
//   init_done    high once the post-reset clear has finished
//   err_inject   (DMEM_PARITY_EN) invert stored parity of written lanes
//   parity_err   (DMEM_PARITY_EN) pulses with rsp_valid on a parity failure
// -----------------------------------------------------------------------------
module data_memory_ctl #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 256
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      write_enable,
  input  logic [ADDR_WIDTH-1:0]     address,
  input  logic [DATA_WIDTH-1:0]     data_input,
  input  logic [DATA_WIDTH/8-1:0]   byte_en,
`ifdef DMEM_PARITY_EN
  input  logic                      err_inject,
  output logic                      parity_err,
`endif
  output logic                      rsp_valid,
  output logic [DATA_WIDTH-1:0]     data_output,
  output logic                      addr_err,
  output logic                      init_done
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
  localparam int LW = 9;   // parity bit sits above the data byte
`else
  localparam int LW = 8;
`endif

  localparam logic [0:0] ST_INIT  = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

  logic [0:0]            state_reg;
  logic [IDX_W-1:0]      clr_ptr_reg;
  logic                  init_done_reg;
  logic                  rsp_valid_reg;
  logic                  addr_err_reg;
  logic                  oor_rd_reg;
  logic [DATA_WIDTH-1:0] hold_reg;

  logic                  in_range;
  logic                  acc;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  clr_we;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] ram_word;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [NB-1:0]         lane_perr;

  // Range check uses the full address; only the low bits index the array.
  assign in_range = ({1'b0, address} < DEPTH_W);
  assign idx      = address[IDX_W-1:0];
  assign acc      = req_valid && req_ready;
  assign rd_acc   = acc && !write_enable;
  assign wr_acc   = acc && write_enable && in_range;
  assign clr_we   = (state_reg == ST_INIT);

  // One RAM per byte lane, so lane masking is a plain per-RAM write enable.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [LW-1:0] lane_mem [DEPTH];
      logic [LW-1:0] lane_q;
      logic [LW-1:0] wr_lane;

`ifdef DMEM_PARITY_EN
      assign wr_lane = {(^data_input[8*gi +: 8]) ^ err_inject, data_input[8*gi +: 8]};
      // Even parity over data+parity must be zero.
      assign lane_perr[gi] = ^lane_q;
`else
      assign wr_lane = data_input[8*gi +: 8];
      assign lane_perr[gi] = 1'b0;
`endif

      always_ff @(posedge clk) begin
        if (clr_we) begin
          lane_mem[clr_ptr_reg] <= '0;   // zero data has zero even parity
        end else if (wr_acc && byte_en[gi]) begin
          lane_mem[idx] <= wr_lane;
        end
        if (rd_acc) begin
          lane_q <= lane_mem[idx];
        end
      end

      assign ram_word[8*gi +: 8] = lane_q[7:0];
    end
  endgenerate

  assign rsp_data = oor_rd_reg ? '0 : ram_word;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      clr_ptr_reg   <= '0;
      init_done_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      addr_err_reg  <= 1'b0;
      oor_rd_reg    <= 1'b0;
      hold_reg      <= '0;
    end else begin
      rsp_valid_reg <= rd_acc;
      addr_err_reg  <= acc && !in_range;
      oor_rd_reg    <= rd_acc && !in_range;
      // Capture the presented response so it persists after the pulse.
      if (rsp_valid_reg) begin
        hold_reg <= rsp_data;
      end
      case (state_reg)
        ST_INIT: begin
          clr_ptr_reg <= clr_ptr_reg + IDX_W'(1);
          if (clr_ptr_reg == LAST_IDX) begin
            state_reg     <= ST_READY;
            init_done_reg <= 1'b1;
          end
        end
        default: begin
          state_reg <= ST_READY;
        end
      endcase
    end
  end

  assign req_ready   = (state_reg == ST_READY);
  assign rsp_valid   = rsp_valid_reg;
  assign addr_err    = addr_err_reg;
  assign init_done   = init_done_reg;
  assign data_output = rsp_valid_reg ? rsp_data : hold_reg;
`ifdef DMEM_PARITY_EN
  assign parity_err  = rsp_valid_reg && !oor_rd_reg && (|lane_perr);
`endif

endmodule

// File: tb/tb_data_memory_ctl.sv
module tb_data_memory_ctl;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int NB = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          write_enable = 1'b0;
  logic [AW-1:0] address = '0;
  logic [DW-1:0] data_input = '0;
  logic [NB-1:0] byte_en = '0;
  logic          rsp_valid;
  logic [DW-1:0] data_output;
  logic          addr_err;
  logic          init_done;
`ifdef DMEM_PARITY_EN
  logic          err_inject = 1'b0;
  logic          parity_err;
`endif

  always #5 clk = ~clk;

  data_memory_ctl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .write_enable (write_enable),
    .address      (address),
    .data_input   (data_input),
    .byte_en      (byte_en),
`ifdef DMEM_PARITY_EN
    .err_inject   (err_inject),
    .parity_err   (parity_err),
`endif
    .rsp_valid    (rsp_valid),
    .data_output  (data_output),
    .addr_err     (addr_err),
    .init_done    (init_done)
  );

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
    logic        inj;
    logic        exp_rsp;
    logic [15:0] exp_data;
    logic        exp_err;
    logic        exp_perr;
  } vec_t;

  typedef struct {
    logic        rsp;
    logic [15:0] data;
    logic        err;
    logic        perr;
    string       name;
  } exp_t;

  exp_t        sb[$];
  vec_t        vecs[24];
  int          n_vec = 0;
  int          errors = 0;
  int          checks = 0;
  logic [15:0] last_data = '0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Compare the outputs produced by the previous edge with the oldest expectation.
  task automatic check_front();
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({e.name, ".rsp_valid"}, 16'(rsp_valid), 16'(e.rsp));
      chk({e.name, ".data_output"}, data_output, e.data);
      chk({e.name, ".addr_err"}, 16'(addr_err), 16'(e.err));
`ifdef DMEM_PARITY_EN
      chk({e.name, ".parity_err"}, 16'(parity_err), 16'(e.perr));
`endif
      $display("txn %s: rsp_valid=%0b data=%h addr_err=%0b", e.name, rsp_valid, data_output, addr_err);
    end
  endtask

  task automatic step(input logic v, input logic we, input logic [15:0] addr,
                      input logic [15:0] data, input logic [1:0] be, input logic inj,
                      input exp_t e);
    @(negedge clk);
    check_front();
    req_valid    = v;
    write_enable = we;
    address      = addr;
    data_input   = data;
    byte_en      = be;
`ifdef DMEM_PARITY_EN
    err_inject   = inj;
`else
    if (inj) $display("note: err_inject ignored without parity");
`endif
    sb.push_back(e);
  endtask

  task automatic idle(input string name);
    exp_t e;
    e.rsp = 1'b0; e.data = last_data; e.err = 1'b0; e.perr = 1'b0; e.name = name;
    step(1'b0, 1'b0, 16'h0, 16'h0, 2'b00, 1'b0, e);
  endtask

  task automatic add_vec(input logic we, input logic [15:0] addr, input logic [15:0] data,
                         input logic [1:0] be, input logic inj, input logic exp_rsp,
                         input logic [15:0] exp_data, input logic exp_err, input logic exp_perr);
    vecs[n_vec] = '{we, addr, data, be, inj, exp_rsp, exp_data, exp_err, exp_perr};
    n_vec++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   bad;
    int   waited;
    exp_t e;

    //          we    addr     data     be     inj   rsp   exp_data err   perr
    add_vec(1'b0, 16'h0005, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0001, 16'hA6A5, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0002, 16'h167D, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0005, 16'hFFFF, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0001, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hA6A5, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0002, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h167D, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0005, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0001, 16'h1234, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0001, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hA634, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0001, 16'h5678, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0001, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hA634, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0100, 16'hBEEF, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_vec(1'b0, 16'h0100, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    add_vec(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b1, 16'hFFFF, 16'h1111, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    add_vec(1'b0, 16'h00FF, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b1, 16'h00FF, 16'hABCD, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h00FF, 16'h0000, 2'b00, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b0);
    add_vec(1'b1, 16'h0000, 16'h5A5A, 2'b10, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h5A00, 1'b0, 1'b0);
`ifdef DMEM_PARITY_EN
    add_vec(1'b1, 16'h0003, 16'h00FF, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b1);
    add_vec(1'b1, 16'h0003, 16'h00FF, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    add_vec(1'b0, 16'h0003, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b0);
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset.req_ready", 16'(req_ready), 16'h0);
    chk("reset.init_done", 16'(init_done), 16'h0);
    chk("reset.rsp_valid", 16'(rsp_valid), 16'h0);
    chk("reset.addr_err", 16'(addr_err), 16'h0);
    chk("reset.data_output", data_output, 16'h0);

    // Hold a read of 0x0005 through INIT: it must not be accepted until READY.
    req_valid = 1'b1; write_enable = 1'b0; address = 16'h0005;
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 256; c++) begin
      if (req_ready !== 1'b0 || init_done !== 1'b0 || rsp_valid !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("init.busy_cycles_bad", 16'(bad), 16'h0);
    chk("init.req_ready_after_256", 16'(req_ready), 16'h1);
    chk("init.init_done_after_256", 16'(init_done), 16'h1);
    e.rsp = 1'b1; e.data = 16'h0000; e.err = 1'b0; e.perr = 1'b0; e.name = "held_read_0005";
    sb.push_back(e);
    last_data = 16'h0000;

    // Table vectors, issued back-to-back.
    for (int i = 0; i < n_vec; i++) begin
      e.rsp  = vecs[i].exp_rsp;
      e.err  = vecs[i].exp_err;
      e.perr = vecs[i].exp_perr;
      if (vecs[i].exp_rsp) last_data = vecs[i].exp_data;
      e.data = last_data;
      e.name = $sformatf("vec%0d", i);
      step(1'b1, vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].inj, e);
    end
    idle("idle_hold0");
    idle("idle_hold1");
    @(negedge clk);
    check_front();

    // Reset while a read response is in flight.
    req_valid = 1'b1; write_enable = 1'b0; address = 16'h0002;
    @(posedge clk);
    #1 rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("midreset.rsp_valid", 16'(rsp_valid), 16'h0);
    chk("midreset.data_output", data_output, 16'h0);
    chk("midreset.init_done", 16'(init_done), 16'h0);
    chk("midreset.req_ready", 16'(req_ready), 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waited = 0;
    while (req_ready !== 1'b1 && waited < 300) begin
      @(negedge clk);
      waited++;
    end
    chk("midreset.ready_within_bound", 16'(req_ready), 16'h1);
    chk("midreset.init_cycles", 16'(waited), 16'd256);
    last_data = 16'h0000;
    e.rsp = 1'b1; e.data = 16'h0000; e.err = 1'b0; e.perr = 1'b0; e.name = "post_reset_read_0002";
    sb.push_back(e);
    req_valid = 1'b1; write_enable = 1'b0; address = 16'h0002;
    idle("post_reset_idle");
    @(negedge clk);
    check_front();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
